// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side end of the rv5stage load/store handshake. It accepts one
// request at a time, performs a word or byte-lane access against an internal
// word array, waits LATENCY extra cycles and then presents a response that is
// held until the consumer takes it.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words in the array
//   LATENCY     : extra wait cycles between acceptance and response (0 allowed)
//   BASE_ADDR   : byte address of word 0 (4-byte aligned)
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst         : asynchronous, active-low reset
//   req_valid   : request present
//   req_ready   : responder can accept a request (registered, high only in IDLE)
//   req_addr    : byte address
//   req_we      : 1 = store, 0 = load
//   req_wdata   : store data, little-endian lanes
//   req_wstrb   : byte-lane write enables (ignored for loads)
//   resp_valid  : response present (registered, high only in RESP)
//   resp_ready  : consumer takes the response
//   resp_rdata  : load data; 0 for stores and errored requests
//   resp_error  : misaligned or out-of-range request
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // Size of the mapped window in bytes, kept in 33 bits to match the offset.
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

    // Value loaded into the wait counter on acceptance; unused when LATENCY=0.
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;

    // Word storage. Contents are deliberately not reset so that stores made
    // before a reset survive it.
    logic [31:0]        mem [DEPTH_WORDS];

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    // The offset is formed in 33 bits: an address below BASE_ADDR produces a
    // borrow into bit 32 instead of wrapping into a large in-range value.
    logic [32:0]        offset;
    logic               addr_err;
    logic [IDX_W-1:0]   word_idx;
    logic               accept;
    logic               do_store;

    always_comb begin
        offset   = {1'b0, req_addr} - {1'b0, BASE_ADDR};
        addr_err = (req_addr[1:0] != 2'b00) || offset[32] || (offset >= SPAN_BYTES);
        word_idx = offset[IDX_W+1:2];
        accept   = (state_reg == IDLE) && req_valid && req_ready;
        do_store = accept && req_we && !addr_err;
    end

    // -------------------------------------------------------------------------
    // Array write port: per-lane byte enables, errored requests never write.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (req_wstrb[i]) begin
                    mem[word_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Handshake FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Ready comes up one edge after reset release or after a
                    // response handshake, then stays up until an accept.
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        resp_error <= addr_err;
                        // The array word is captured at acceptance, so a store
                        // committed on an earlier accept is already visible.
                        resp_rdata <= (req_we || addr_err) ? 32'h0 : mem[word_idx];
                        if (LATENCY > 0) begin
                            state_reg <= WAIT;
                            cnt_reg   <= CNT_INIT;
                        end else begin
                            state_reg  <= RESP;
                            resp_valid <= 1'b1;
                        end
                    end
                end

                WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg  <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                RESP: begin
                    // Data and error stay put until the consumer takes them.
                    // Ready returns only after the handshake edge, so no new
                    // request can be accepted in the handshake cycle.
                    if (resp_ready) begin
                        state_reg  <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end

                default: begin
                    state_reg  <= IDLE;
                    req_ready  <= 1'b0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
